// File: rtl/renkon_core_ctrl_pkg.sv
// Shared constants and state encoding for the renkon_core lane sequencer.
package renkon_core_ctrl_pkg;
   localparam int KSIZE     = 25;
   localparam int FACCUM    = 10;
   localparam int LWIDTH    = 10;
   localparam int NWIDTH    = 12;
   localparam int OUT_PIPE  = 4;
   localparam int DRAIN_LEN = OUT_PIPE + 1;
   localparam int KCW       = $clog2(KSIZE);
   localparam int DCW       = $clog2(DRAIN_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_WEIGHT, S_ACCUM, S_BIAS, S_OUT, S_DRAIN
   } state_e;

   // Latched limit for a count field; a zero count behaves as one.
   function automatic logic [LWIDTH-1:0] last_of(input logic [LWIDTH-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction
endpackage

// File: rtl/renkon_ctrl_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module renkon_ctrl_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!xrst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/renkon_core_ctrl.sv
// Lane sequencer: per input channel load a kernel and accumulate the map,
// then load the bias and stream the map through bias/relu/pool.
module renkon_core_ctrl
   import renkon_core_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              xrst,
   input  logic              req,
   input  logic [LWIDTH-1:0] n_in,
   input  logic [LWIDTH-1:0] fea_size,
   input  logic [LWIDTH-1:0] pool_size,
   input  logic [NWIDTH-1:0] net_base,
   output logic              ack,
   output logic [NWIDTH-1:0] net_addr,
   output logic              wreg_we,
   output logic              breg_we,
   output logic [FACCUM-1:0] mem_feat_addr,
   output logic [FACCUM-1:0] mem_feat_addr_d1,
   output logic              mem_feat_we,
   output logic              mem_feat_rst,
   output logic              conv_oe,
   output logic              bias_oe,
   output logic              relu_oe,
   output logic              pool_oe,
   output logic              buf_feat_en,
   output logic              pmap_valid
);
   state_e            state_q, state_d;
   logic [NWIDTH-1:0] net_addr_q, net_addr_d;
   logic [KCW-1:0]    kcnt_q, kcnt_d;
   logic [DCW-1:0]    dcnt_q, dcnt_d;
   logic [FACCUM-1:0] faddr_q, faddr_d;
   logic [LWIDTH-1:0] ch_q, ch_d, row_q, row_d, col_q, col_d;
   logic [LWIDTH-1:0] prow_q, prow_d, pcol_q, pcol_d;
   logic [LWIDTH-1:0] nlast_q, nlast_d, flast_q, flast_d, plast_q, plast_d;
   logic              pool_hit;

   always_ff @(posedge clk) begin
      if (!xrst) begin
         state_q    <= S_IDLE;
         net_addr_q <= '0;
         kcnt_q     <= '0;
         dcnt_q     <= '0;
         faddr_q    <= '0;
         ch_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         prow_q     <= '0;
         pcol_q     <= '0;
         nlast_q    <= '0;
         flast_q    <= '0;
         plast_q    <= '0;
      end else begin
         state_q    <= state_d;
         net_addr_q <= net_addr_d;
         kcnt_q     <= kcnt_d;
         dcnt_q     <= dcnt_d;
         faddr_q    <= faddr_d;
         ch_q       <= ch_d;
         row_q      <= row_d;
         col_q      <= col_d;
         prow_q     <= prow_d;
         pcol_q     <= pcol_d;
         nlast_q    <= nlast_d;
         flast_q    <= flast_d;
         plast_q    <= plast_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      net_addr_d = net_addr_q;
      kcnt_d     = kcnt_q;
      dcnt_d     = dcnt_q;
      faddr_d    = faddr_q;
      ch_d       = ch_q;
      row_d      = row_q;
      col_d      = col_q;
      prow_d     = prow_q;
      pcol_d     = pcol_q;
      nlast_d    = nlast_q;
      flast_d    = flast_q;
      plast_d    = plast_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               nlast_d    = last_of(n_in);
               flast_d    = last_of(fea_size);
               plast_d    = last_of(pool_size);
               net_addr_d = net_base;
               ch_d       = '0;
               kcnt_d     = '0;
               state_d    = S_WEIGHT;
            end
         end
         S_WEIGHT: begin
            net_addr_d = net_addr_q + 1'b1;
            kcnt_d     = kcnt_q + 1'b1;
            if (kcnt_q == KCW'(KSIZE - 1)) begin
               kcnt_d  = '0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM, S_OUT: begin
            // Raster scan; the pool-window counters restart with every row/map wrap.
            faddr_d = faddr_q + 1'b1;
            col_d   = col_q + 1'b1;
            pcol_d  = (pcol_q == plast_q) ? '0 : pcol_q + 1'b1;
            if (col_q == flast_q) begin
               col_d  = '0;
               pcol_d = '0;
               row_d  = row_q + 1'b1;
               prow_d = (prow_q == plast_q) ? '0 : prow_q + 1'b1;
               if (row_q == flast_q) begin
                  row_d   = '0;
                  prow_d  = '0;
                  faddr_d = '0;
                  if (state_q == S_OUT) begin
                     dcnt_d  = '0;
                     state_d = S_DRAIN;
                  end else if (ch_q == nlast_q) begin
                     state_d = S_BIAS;
                  end else begin
                     ch_d    = ch_q + 1'b1;
                     state_d = S_WEIGHT;
                  end
               end
            end
         end
         S_BIAS: state_d = S_OUT;
         S_DRAIN: begin
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q == DCW'(DRAIN_LEN - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pool_hit      = (prow_q == plast_q) && (pcol_q == plast_q);
   assign ack           = (state_q == S_IDLE);
   assign net_addr      = net_addr_q;
   assign mem_feat_addr = faddr_q;

   // One-cycle memory read latency for weights, bias and accumulator writes.
   renkon_ctrl_delay #(.WIDTH(4), .DEPTH(1)) u_mem_dly (
      .clk  (clk),
      .xrst (xrst),
      .d_i  ({state_q == S_WEIGHT, state_q == S_ACCUM,
              (state_q == S_ACCUM) && (ch_q == '0), state_q == S_BIAS}),
      .q_o  ({wreg_we, mem_feat_we, mem_feat_rst, breg_we})
   );

   renkon_ctrl_delay #(.WIDTH(FACCUM), .DEPTH(1)) u_addr_dly (
      .clk  (clk),
      .xrst (xrst),
      .d_i  (faddr_q),
      .q_o  (mem_feat_addr_d1)
   );

   logic oe_pipe   [OUT_PIPE+1];
   logic pool_pipe [OUT_PIPE+1];

   assign oe_pipe[0]   = (state_q == S_OUT);
   assign pool_pipe[0] = (state_q == S_OUT) && pool_hit;

   generate
      for (genvar gi = 0; gi < OUT_PIPE; gi++) begin : g_out_pipe
         renkon_ctrl_delay #(.WIDTH(2), .DEPTH(1)) u_stage (
            .clk  (clk),
            .xrst (xrst),
            .d_i  ({oe_pipe[gi], pool_pipe[gi]}),
            .q_o  ({oe_pipe[gi+1], pool_pipe[gi+1]})
         );
      end
   endgenerate

   renkon_ctrl_delay #(.WIDTH(1), .DEPTH(1)) u_pmap_dly (
      .clk  (clk),
      .xrst (xrst),
      .d_i  (pool_pipe[OUT_PIPE]),
      .q_o  (pmap_valid)
   );

   assign conv_oe     = oe_pipe[1];
   assign bias_oe     = oe_pipe[2];
   assign relu_oe     = oe_pipe[3];
   assign buf_feat_en = oe_pipe[4];
   assign pool_oe     = pool_pipe[OUT_PIPE];
endmodule

// File: tb/tb_renkon_core_ctrl.sv
// Self-checking bench for renkon_core_ctrl: config table plus scoreboard queues.
module tb_renkon_core_ctrl;
   import renkon_core_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              xrst, req;
   logic [LWIDTH-1:0] n_in, fea_size, pool_size;
   logic [NWIDTH-1:0] net_base;
   logic              ack, wreg_we, breg_we, mem_feat_we, mem_feat_rst;
   logic [NWIDTH-1:0] net_addr;
   logic [FACCUM-1:0] mem_feat_addr, mem_feat_addr_d1;
   logic              conv_oe, bias_oe, relu_oe, pool_oe, buf_feat_en, pmap_valid;

   renkon_core_ctrl dut (
      .clk(clk), .xrst(xrst), .req(req), .n_in(n_in), .fea_size(fea_size),
      .pool_size(pool_size), .net_base(net_base), .ack(ack), .net_addr(net_addr),
      .wreg_we(wreg_we), .breg_we(breg_we), .mem_feat_addr(mem_feat_addr),
      .mem_feat_addr_d1(mem_feat_addr_d1), .mem_feat_we(mem_feat_we),
      .mem_feat_rst(mem_feat_rst), .conv_oe(conv_oe), .bias_oe(bias_oe),
      .relu_oe(relu_oe), .pool_oe(pool_oe), .buf_feat_en(buf_feat_en),
      .pmap_valid(pmap_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n; int fs; int ps; int base; bit mess; int exp_cycles; int exp_pool;
   } vec_t;

   vec_t vecs [6];
   int   checks = 0;
   int   failures = 0;
   int   pmap_cnt = 0;
   int   wq[$], fq[$], bq[$], cq[$];
   bit   pq[$];

   logic              rst_edge = 1'b1;
   logic [NWIDTH-1:0] prev_net = '0;
   logic [FACCUM-1:0] prev_faddr = '0;
   logic              prev_conv = 1'b0, prev_bias = 1'b0, prev_relu = 1'b0, prev_pool = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) rst_edge <= !xrst;

   // Scoreboard: every DUT pulse pops the expectation pushed when the run started.
   always @(negedge clk) begin
      if (wreg_we) begin
         if (wq.size() == 0) chk("wreg_unexpected", 1, 0);
         else chk("wreg_addr", prev_net, wq.pop_front());
      end
      if (mem_feat_we) begin
         if (fq.size() == 0) chk("feat_we_unexpected", 1, 0);
         else chk("feat_we_addr_rst", {mem_feat_addr_d1, mem_feat_rst}, fq.pop_front());
      end
      if (mem_feat_rst && !mem_feat_we) chk("feat_rst_alone", 1, 0);
      if (breg_we) begin
         if (bq.size() == 0) chk("breg_unexpected", 1, 0);
         else chk("bias_addr", prev_net, bq.pop_front());
      end
      if (conv_oe) begin
         if (cq.size() == 0) chk("conv_unexpected", 1, 0);
         else chk("conv_pixel", mem_feat_addr_d1, cq.pop_front());
      end
      if (buf_feat_en) begin
         if (pq.size() == 0) chk("buf_unexpected", 1, 0);
         else chk("pool_oe", pool_oe, pq.pop_front());
      end
      if (pool_oe && !buf_feat_en) chk("pool_without_buf", 1, 0);
      if (pmap_valid) pmap_cnt++;
      chk("feat_addr_d1", mem_feat_addr_d1, rst_edge ? '0 : prev_faddr);
      chk("bias_shift", bias_oe, rst_edge ? 1'b0 : prev_conv);
      chk("relu_shift", relu_oe, rst_edge ? 1'b0 : prev_bias);
      chk("buf_shift", buf_feat_en, rst_edge ? 1'b0 : prev_relu);
      chk("pmap_shift", pmap_valid, rst_edge ? 1'b0 : prev_pool);
      prev_net   <= net_addr;
      prev_faddr <= mem_feat_addr;
      prev_conv  <= conv_oe;
      prev_bias  <= bias_oe;
      prev_relu  <= relu_oe;
      prev_pool  <= pool_oe;
   end

   task automatic start_run(input vec_t v);
      int nn, ff, pp, npix, addr;
      nn = (v.n == 0) ? 1 : v.n;
      ff = (v.fs == 0) ? 1 : v.fs;
      pp = (v.ps == 0) ? 1 : v.ps;
      npix = ff * ff;
      addr = v.base;
      for (int c = 0; c < nn; c++) begin
         for (int k = 0; k < KSIZE; k++) begin
            wq.push_back(addr & 'hfff);
            addr++;
         end
         for (int p = 0; p < npix; p++) fq.push_back(p * 2 + ((c == 0) ? 1 : 0));
      end
      bq.push_back(addr & 'hfff);
      for (int p = 0; p < npix; p++) begin
         cq.push_back(p);
         pq.push_back((((p / ff) % pp) == pp - 1) && (((p % ff) % pp) == pp - 1));
      end
      pmap_cnt  = 0;
      req       = 1'b1;
      n_in      = LWIDTH'(v.n);
      fea_size  = LWIDTH'(v.fs);
      pool_size = LWIDTH'(v.ps);
      net_base  = NWIDTH'(v.base);
      @(posedge clk); #1;
      req = 1'b0;
      chk("ack_drop", ack, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int cycles;
      start_run(v);
      cycles = 1;
      while (!ack && cycles < 5000) begin
         if (v.mess) begin
            req       = 1'($urandom_range(0, 1));
            n_in      = LWIDTH'($urandom_range(0, 7));
            fea_size  = LWIDTH'($urandom_range(0, 31));
            pool_size = LWIDTH'($urandom_range(0, 4));
            net_base  = NWIDTH'($urandom_range(0, 4095));
         end
         @(posedge clk); #1;
         cycles++;
      end
      req = 1'b0;
      chk("req_to_ack_cycles", cycles, v.exp_cycles);
      chk("pmap_count", pmap_cnt, v.exp_pool);
      chk("wreg_left", wq.size(), 0);
      chk("feat_we_left", fq.size(), 0);
      chk("bias_left", bq.size(), 0);
      chk("conv_left", cq.size(), 0);
      chk("pool_left", pq.size(), 0);
      $display("run n_in=%0d fea=%0d pool=%0d base=%0h mess=%0d cycles=%0d pmaps=%0d",
               v.n, v.fs, v.ps, v.base, v.mess, cycles, pmap_cnt);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      xrst = 1'b0; req = 1'b0; n_in = '0; fea_size = '0; pool_size = '0; net_base = '0;
      vecs[0] = '{1, 4, 2, 'h100, 1'b0, 64, 4};
      vecs[1] = '{3, 2, 1, 'h040, 1'b0, 98, 4};
      vecs[2] = '{1, 3, 2, 'h000, 1'b0, 50, 1};
      vecs[3] = '{2, 4, 4, 'h200, 1'b1, 105, 1};
      vecs[4] = '{0, 0, 1, 'h010, 1'b0, 34, 1};
      vecs[5] = '{1, 5, 2, 'hf00, 1'b0, 82, 4};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ack, 1);
      chk("rst_net_addr", net_addr, 0);
      chk("rst_feat_addr", mem_feat_addr, 0);
      chk("rst_enables", {wreg_we, breg_we, mem_feat_we, mem_feat_rst, conv_oe, pool_oe, pmap_valid}, 0);
      xrst = 1'b1;
      @(posedge clk); #1;
      chk("idle_ack", ack, 1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort during the second accumulate cycle, then restart cleanly.
      start_run(vecs[0]);
      repeat (26) @(posedge clk);
      #1;
      chk("mid_accum_addr", mem_feat_addr, 1);
      xrst = 1'b0;
      @(posedge clk); #1;
      chk("abort_ack", ack, 1);
      chk("abort_enables", {wreg_we, breg_we, mem_feat_we, mem_feat_rst, conv_oe,
                            bias_oe, relu_oe, buf_feat_en, pool_oe, pmap_valid}, 0);
      chk("abort_feat_addr", mem_feat_addr, 0);
      chk("abort_writes_left", fq.size(), 15);
      xrst = 1'b1;
      wq.delete(); fq.delete(); bq.delete(); cq.delete(); pq.delete();
      $display("reset abort during accumulate applied");
      @(posedge clk); #1;
      chk("abort_stays_idle", {ack, mem_feat_we, wreg_we}, 3'b100);
      run_vec(vecs[0]);
      run_vec(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
